// File: rtl/jump_ret_unit.sv
// jump_ret_unit: drive side of the PC jump interface.
// Decodes JMP/CALL/RET, keeps a return-address LIFO and latches a sticky
// fault on stack overflow/underflow that blocks all jumps until reset.
// Jump select/address are combinational so the PC takes the jump on the
// same posedge the request is presented.
module jump_ret_unit #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              i_CLK,
  input  logic              i_RST,
  input  logic              i_VALID,
  input  logic [1:0]        i_OP,
  input  logic [ADDR_W-1:0] i_TARGET,
  input  logic [ADDR_W-1:0] i_PC,
  output logic              o_SEL_JMP,
  output logic [ADDR_W-1:0] o_JMP_ADDR,
  output logic              o_EMPTY,
  output logic              o_FULL,
  output logic              o_FAULT
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_JMP  = 2'b01;
  localparam logic [1:0] OP_CALL = 2'b10;
  localparam logic [1:0] OP_RET  = 2'b11;

  typedef enum logic {S_RUN, S_FAULT} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     count, count_nxt;
  logic [ADDR_W-1:0] stack [DEPTH];
  logic              push;
  logic [IW-1:0]     wr_idx;
  logic [IW-1:0]     top_idx;
  logic [ADDR_W-1:0] ret_addr;
  logic              empty, full;

  // Count is the number of live entries: next free slot is count, top is
  // count-1. When full, count[IW-1:0] wraps to 0 so the subtraction still
  // lands on DEPTH-1.
  assign wr_idx   = count[IW-1:0];
  assign top_idx  = count[IW-1:0] - IW'(1);
  assign ret_addr = i_PC + ADDR_W'(1);
  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));

  assign o_EMPTY = empty;
  assign o_FULL  = full;
  assign o_FAULT = (state == S_FAULT);

  // Request decode: jump outputs, stack update and fault transition.
  always_comb begin
    o_SEL_JMP  = 1'b0;
    o_JMP_ADDR = '0;
    push       = 1'b0;
    count_nxt  = count;
    state_nxt  = state;
    if (state == S_RUN && i_VALID) begin
      case (i_OP)
        OP_JMP: begin
          o_SEL_JMP  = 1'b1;
          o_JMP_ADDR = i_TARGET;
        end
        OP_CALL: begin
          if (full) begin
            state_nxt = S_FAULT;
          end else begin
            o_SEL_JMP  = 1'b1;
            o_JMP_ADDR = i_TARGET;
            push       = 1'b1;
            count_nxt  = count + CW'(1);
          end
        end
        OP_RET: begin
          if (empty) begin
            state_nxt = S_FAULT;
          end else begin
            o_SEL_JMP  = 1'b1;
            o_JMP_ADDR = stack[top_idx];
            count_nxt  = count - CW'(1);
          end
        end
        OP_NOP: ;
        default: ;
      endcase
    end
  end

  // State and occupancy registers; reset overrides any same-cycle request.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state <= S_RUN;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  // Stack storage; contents are don't-care after reset, so no reset here.
  always_ff @(posedge i_CLK) begin
    if (!i_RST && push)
      stack[wr_idx] <= ret_addr;
  end

endmodule

// File: tb/tb_jump_ret_unit.sv
// Directed bench for jump_ret_unit (ADDR_W=8, DEPTH=4).
module tb_jump_ret_unit;

  logic       clk = 1'b0;
  logic       rst, valid;
  logic [1:0] op;
  logic [7:0] target, pc;
  logic       sel_jmp, empty, full, fault;
  logic [7:0] jmp_addr;

  int checks = 0;
  int errors = 0;

  jump_ret_unit #(.ADDR_W(8), .DEPTH(4)) dut (
    .i_CLK(clk), .i_RST(rst), .i_VALID(valid), .i_OP(op),
    .i_TARGET(target), .i_PC(pc), .o_SEL_JMP(sel_jmp),
    .o_JMP_ADDR(jmp_addr), .o_EMPTY(empty), .o_FULL(full), .o_FAULT(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request, let comb logic settle.
  task automatic req(input logic v, input logic [1:0] o, input logic [7:0] t, input logic [7:0] p);
    valid = v; op = o; target = t; pc = p;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; valid = 1'b0; op = 2'b00; target = '0; pc = '0;
    step();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b0; valid = 1'b0; op = 2'b00; target = '0; pc = '0;
    do_reset();
    chk("rst_empty", empty, 1);
    chk("rst_full",  full,  0);
    chk("rst_sel",   sel_jmp, 0);
    chk("rst_addr",  jmp_addr, 0);
    chk("rst_fault", fault, 0);

    // 1: plain JMP
    req(1, 2'b01, 8'h40, 8'h00);
    chk("jmp_sel",  sel_jmp, 1);
    chk("jmp_addr", jmp_addr, 8'h40);
    step();
    chk("jmp_empty", empty, 1);

    // 2: nested CALL/RET
    req(1, 2'b10, 8'h10, 8'h05);
    chk("call1_sel",  sel_jmp, 1);
    chk("call1_addr", jmp_addr, 8'h10);
    step();
    chk("call1_empty", empty, 0);
    req(1, 2'b10, 8'h20, 8'h12);
    chk("call2_addr", jmp_addr, 8'h20);
    step();
    chk("call2_full", full, 0);
    req(1, 2'b11, 8'h00, 8'h21);
    chk("ret1_sel",  sel_jmp, 1);
    chk("ret1_addr", jmp_addr, 8'h13);
    step();
    chk("ret1_empty", empty, 0);
    req(1, 2'b11, 8'h00, 8'h14);
    chk("ret2_addr", jmp_addr, 8'h06);
    step();
    chk("ret2_empty", empty, 1);
    req(0, 2'b00, 8'h00, 8'h00);
    chk("idle_addr", jmp_addr, 0);

    // 3: overflow
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req(1, 2'b10, 8'h50, 8'(i));
      chk("fill_sel", sel_jmp, 1);
      step();
    end
    chk("fill_full", full, 1);
    req(1, 2'b10, 8'h60, 8'h09);
    chk("ovf_sel",  sel_jmp, 0);
    chk("ovf_addr", jmp_addr, 0);
    chk("ovf_fault_pre", fault, 0);
    step();
    chk("ovf_fault", fault, 1);
    req(1, 2'b01, 8'h80, 8'h00);
    chk("flt_jmp_sel", sel_jmp, 0);
    req(1, 2'b11, 8'h00, 8'h00);
    chk("flt_ret_sel", sel_jmp, 0);
    step();
    chk("flt_frozen_full", full, 1);
    chk("flt_hold", fault, 1);

    // 4: underflow and recovery
    do_reset();
    req(1, 2'b11, 8'h00, 8'h00);
    chk("unf_sel", sel_jmp, 0);
    step();
    chk("unf_fault", fault, 1);
    do_reset();
    chk("rec_fault", fault, 0);
    chk("rec_empty", empty, 1);
    req(1, 2'b01, 8'h55, 8'h00);
    chk("rec_jmp_sel",  sel_jmp, 1);
    chk("rec_jmp_addr", jmp_addr, 8'h55);
    step();

    // 5: return-address wrap
    req(1, 2'b10, 8'h30, 8'hFF);
    chk("wrap_call_addr", jmp_addr, 8'h30);
    step();
    req(1, 2'b11, 8'h00, 8'h30);
    chk("wrap_ret_sel",  sel_jmp, 1);
    chk("wrap_ret_addr", jmp_addr, 8'h00);
    step();
    chk("wrap_empty", empty, 1);

    // 6: reset beats request; invalid request ignored
    rst = 1'b1;
    req(1, 2'b10, 8'h70, 8'h22);
    step();
    rst = 1'b0;
    req(0, 2'b00, 8'h00, 8'h00);
    chk("rstcall_empty", empty, 1);
    req(0, 2'b01, 8'h77, 8'h00);
    chk("inv_sel",  sel_jmp, 0);
    chk("inv_addr", jmp_addr, 0);
    step();
    chk("inv_fault", fault, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
